// File: rtl/ticket_fifo_pkg.sv
// Shared types and defaults for the ticket FIFO bank, its bus interface and the page allocator.
package ticket_fifo_pkg;

   localparam int unsigned N_LANE_DFLT            = 4;
   localparam int unsigned TICKET_FIFO_DEPTH_DFLT = 1024;
   localparam int unsigned TICKET_W_DFLT          = 64;
   localparam int unsigned TICKET_ADDR_W_DFLT     = $clog2(TICKET_FIFO_DEPTH_DFLT);

   typedef logic [TICKET_ADDR_W_DFLT-1:0] ticket_ptr_t;
   typedef logic [TICKET_W_DFLT-1:0]      ticket_t;

   // Pointer subtraction wraps naturally at the pointer width, giving (a - b) mod DEPTH.
   function automatic ticket_ptr_t ptr_dist(input ticket_ptr_t a, input ticket_ptr_t b);
      return a - b;
   endfunction

endpackage

// File: rtl/ticket_fifo_bank_if.sv
// Flat per-lane bus between the ticket FIFO bank (slave) and its ingress/allocator side (master).
interface ticket_fifo_bank_if
   import ticket_fifo_pkg::*;
#(
   parameter int unsigned N_LANE        = N_LANE_DFLT,
   parameter int unsigned TICKET_W      = TICKET_W_DFLT,
   parameter int unsigned TICKET_ADDR_W = TICKET_ADDR_W_DFLT,
   parameter int unsigned OVF_CNT_W     = 16
);

   logic [N_LANE-1:0]                     wr_valid;
   logic [N_LANE*TICKET_W-1:0]            wr_data_flat;
   logic [N_LANE-1:0]                     wr_ready;
   logic [N_LANE-1:0]                     flush;
   logic [N_LANE*TICKET_ADDR_W-1:0]       ticket_wptr_flat;
   logic [N_LANE*TICKET_ADDR_W-1:0]       ticket_rd_addr_flat;
   logic [N_LANE*TICKET_W-1:0]            ticket_rd_data_flat;
   logic [N_LANE-1:0]                     ticket_credit_update_valid;
   logic [N_LANE*TICKET_ADDR_W-1:0]       ticket_credit_update_flat;
   logic [N_LANE*(TICKET_ADDR_W+1)-1:0]   used_flat;
   logic [N_LANE-1:0]                     afull;
   logic [N_LANE*OVF_CNT_W-1:0]           ovf_cnt_flat;
   logic [N_LANE-1:0]                     ovf_sticky;
   logic [N_LANE-1:0]                     credit_err;

   modport master (
      output wr_valid, wr_data_flat, flush, ticket_rd_addr_flat,
             ticket_credit_update_valid, ticket_credit_update_flat,
      input  wr_ready, ticket_wptr_flat, ticket_rd_data_flat, used_flat, afull,
             ovf_cnt_flat, ovf_sticky, credit_err
   );

   modport slave (
      input  wr_valid, wr_data_flat, flush, ticket_rd_addr_flat,
             ticket_credit_update_valid, ticket_credit_update_flat,
      output wr_ready, ticket_wptr_flat, ticket_rd_data_flat, used_flat, afull,
             ovf_cnt_flat, ovf_sticky, credit_err
   );

endinterface

// File: rtl/ticket_lane_fifo.sv
// One ticket FIFO lane: RAM with registered random-access read, credit-driven read pointer,
// fill level, almost-full, flush and drop/credit-error accounting.
module ticket_lane_fifo
   import ticket_fifo_pkg::*;
#(
   parameter int unsigned DEPTH        = TICKET_FIFO_DEPTH_DFLT,
   parameter int unsigned W            = TICKET_W_DFLT,
   parameter int unsigned AFULL_THR    = 768,
   parameter bit          DROP_ON_FULL = 1'b1,
   parameter int unsigned OVF_CNT_W    = 16,
   parameter int unsigned ADDR_W       = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_wr_valid,
   input  logic [W-1:0]         i_wr_data,
   output logic                 o_wr_ready,
   input  logic                 i_flush,
   output logic [ADDR_W-1:0]    o_wptr,
   input  logic [ADDR_W-1:0]    i_rd_addr,
   output logic [W-1:0]         o_rd_data,
   input  logic                 i_credit_valid,
   input  logic [ADDR_W-1:0]    i_credit,
   output logic [ADDR_W:0]      o_used,
   output logic                 o_afull,
   output logic [OVF_CNT_W-1:0] o_ovf_cnt,
   output logic                 o_ovf_sticky,
   output logic                 o_credit_err
);

   localparam logic [ADDR_W:0] FULL_LVL  = (ADDR_W+1)'(DEPTH - 1);
   localparam logic [ADDR_W:0] AFULL_LVL = (ADDR_W+1)'(AFULL_THR);

   logic [W-1:0]         r_mem [DEPTH];
   logic [ADDR_W-1:0]    r_wptr;
   logic [ADDR_W-1:0]    r_rptr;
   logic [ADDR_W:0]      r_used;
   logic                 r_afull;
   logic [W-1:0]         r_rd_data;
   logic [OVF_CNT_W-1:0] r_ovf_cnt;
   logic                 r_ovf_sticky;
   logic                 r_credit_err;

   logic                 w_full;
   logic [ADDR_W-1:0]    w_dist;
   logic                 w_credit_ok;
   logic                 w_credit_bad;
   logic                 w_wr_acc;
   logic                 w_drop;
   logic [ADDR_W-1:0]    w_rptr_nxt;
   logic [ADDR_W-1:0]    w_wptr_nxt;
   logic [ADDR_W:0]      w_used_nxt;

   // Every decision uses pre-update state; flush rebases wptr onto the post-credit rptr.
   always_comb begin
      w_full       = (r_used == FULL_LVL);
      w_dist       = i_credit - r_rptr;
      w_credit_ok  = i_credit_valid && ({1'b0, w_dist} <= r_used);
      w_credit_bad = i_credit_valid && !w_credit_ok;
      w_wr_acc     = i_wr_valid && !w_full && !i_flush;
      w_drop       = DROP_ON_FULL && i_wr_valid && w_full && !i_flush;
      w_rptr_nxt   = w_credit_ok ? i_credit : r_rptr;
      if (i_flush) begin
         w_wptr_nxt = w_rptr_nxt;
      end else if (w_wr_acc) begin
         w_wptr_nxt = r_wptr + 1'b1;
      end else begin
         w_wptr_nxt = r_wptr;
      end
      w_used_nxt   = {1'b0, w_wptr_nxt - w_rptr_nxt};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr       <= '0;
         r_rptr       <= '0;
         r_used       <= '0;
         r_afull      <= 1'b0;
         r_rd_data    <= '0;
         r_ovf_cnt    <= '0;
         r_ovf_sticky <= 1'b0;
         r_credit_err <= 1'b0;
      end else begin
         r_wptr    <= w_wptr_nxt;
         r_rptr    <= w_rptr_nxt;
         r_used    <= w_used_nxt;
         r_afull   <= (w_used_nxt >= AFULL_LVL);
         r_rd_data <= r_mem[i_rd_addr];
         if (w_drop) begin
            r_ovf_sticky <= 1'b1;
            if (r_ovf_cnt != '1) r_ovf_cnt <= r_ovf_cnt + 1'b1;
         end
         if (w_credit_bad) r_credit_err <= 1'b1;
      end
   end

   // Storage is intentionally not reset.
   always_ff @(posedge clk) begin
      if (w_wr_acc) r_mem[r_wptr] <= i_wr_data;
   end

   assign o_wr_ready   = DROP_ON_FULL ? 1'b1 : !w_full;
   assign o_wptr       = r_wptr;
   assign o_rd_data    = r_rd_data;
   assign o_used       = r_used;
   assign o_afull      = r_afull;
   assign o_ovf_cnt    = r_ovf_cnt;
   assign o_ovf_sticky = r_ovf_sticky;
   assign o_credit_err = r_credit_err;

endmodule

// File: rtl/ticket_fifo_bank.sv
// N_LANE independent ticket FIFO lanes behind one flat-bus interface.
module ticket_fifo_bank
   import ticket_fifo_pkg::*;
#(
   parameter int unsigned N_LANE            = N_LANE_DFLT,
   parameter int unsigned TICKET_FIFO_DEPTH = TICKET_FIFO_DEPTH_DFLT,
   parameter int unsigned TICKET_W          = TICKET_W_DFLT,
   parameter int unsigned AFULL_THR         = 768,
   parameter bit          DROP_ON_FULL      = 1'b1,
   parameter int unsigned OVF_CNT_W         = 16
) (
   input logic               clk,
   input logic               rst_n,
   ticket_fifo_bank_if.slave bus
);

   localparam int unsigned TICKET_ADDR_W = $clog2(TICKET_FIFO_DEPTH);
   localparam int unsigned USED_W        = TICKET_ADDR_W + 1;

   logic                     w_wr_ready   [N_LANE];
   logic [TICKET_ADDR_W-1:0] w_wptr       [N_LANE];
   logic [TICKET_W-1:0]      w_rd_data    [N_LANE];
   logic [USED_W-1:0]        w_used       [N_LANE];
   logic                     w_afull      [N_LANE];
   logic [OVF_CNT_W-1:0]     w_ovf_cnt    [N_LANE];
   logic                     w_ovf_sticky [N_LANE];
   logic                     w_credit_err [N_LANE];

   for (genvar g = 0; g < N_LANE; g++) begin : g_lane
      ticket_lane_fifo #(
         .DEPTH        (TICKET_FIFO_DEPTH),
         .W            (TICKET_W),
         .AFULL_THR    (AFULL_THR),
         .DROP_ON_FULL (DROP_ON_FULL),
         .OVF_CNT_W    (OVF_CNT_W),
         .ADDR_W       (TICKET_ADDR_W)
      ) u_lane (
         .clk            (clk),
         .rst_n          (rst_n),
         .i_wr_valid     (bus.wr_valid[g]),
         .i_wr_data      (bus.wr_data_flat[g*TICKET_W +: TICKET_W]),
         .o_wr_ready     (w_wr_ready[g]),
         .i_flush        (bus.flush[g]),
         .o_wptr         (w_wptr[g]),
         .i_rd_addr      (bus.ticket_rd_addr_flat[g*TICKET_ADDR_W +: TICKET_ADDR_W]),
         .o_rd_data      (w_rd_data[g]),
         .i_credit_valid (bus.ticket_credit_update_valid[g]),
         .i_credit       (bus.ticket_credit_update_flat[g*TICKET_ADDR_W +: TICKET_ADDR_W]),
         .o_used         (w_used[g]),
         .o_afull        (w_afull[g]),
         .o_ovf_cnt      (w_ovf_cnt[g]),
         .o_ovf_sticky   (w_ovf_sticky[g]),
         .o_credit_err   (w_credit_err[g])
      );
   end

   always_comb begin
      bus.wr_ready            = '0;
      bus.ticket_wptr_flat    = '0;
      bus.ticket_rd_data_flat = '0;
      bus.used_flat           = '0;
      bus.afull               = '0;
      bus.ovf_cnt_flat        = '0;
      bus.ovf_sticky          = '0;
      bus.credit_err          = '0;
      for (int i = 0; i < N_LANE; i++) begin
         bus.wr_ready[i]                                     = w_wr_ready[i];
         bus.ticket_wptr_flat[i*TICKET_ADDR_W +: TICKET_ADDR_W] = w_wptr[i];
         bus.ticket_rd_data_flat[i*TICKET_W +: TICKET_W]     = w_rd_data[i];
         bus.used_flat[i*USED_W +: USED_W]                   = w_used[i];
         bus.afull[i]                                        = w_afull[i];
         bus.ovf_cnt_flat[i*OVF_CNT_W +: OVF_CNT_W]          = w_ovf_cnt[i];
         bus.ovf_sticky[i]                                   = w_ovf_sticky[i];
         bus.credit_err[i]                                   = w_credit_err[i];
      end
   end

endmodule

// File: tb/tb_ticket_fifo_bank.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-level lane model.
module tb_ticket_fifo_bank;

   localparam int NL = 4;
   localparam int D  = 1024;
   localparam int AW = 10;
   localparam int UW = 11;
   localparam int TW = 64;
   localparam int CW = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   ticket_fifo_bank_if #(.N_LANE(NL), .TICKET_W(TW), .TICKET_ADDR_W(AW), .OVF_CNT_W(CW)) bus1 ();
   ticket_fifo_bank_if #(.N_LANE(NL), .TICKET_W(TW), .TICKET_ADDR_W(AW), .OVF_CNT_W(CW)) bus0 ();

   ticket_fifo_bank #(.DROP_ON_FULL(1'b1)) dut_drop (.clk(clk), .rst_n(rst_n), .bus(bus1));
   ticket_fifo_bank #(.DROP_ON_FULL(1'b0)) dut_bp   (.clk(clk), .rst_n(rst_n), .bus(bus0));

   int n_checks = 0;
   int n_fail   = 0;

   // Stimulus for the drop-mode instance.
   bit          s_wv [NL];
   bit          s_fl [NL];
   bit          s_cv [NL];
   logic [63:0] s_wd [NL];
   int          s_cr [NL];
   int          s_ra [NL];

   // Lane model: pointers as plain integers, ticket store as an array.
   int          m_w [NL];
   int          m_r [NL];
   int          m_ovf [NL];
   bit          m_st [NL];
   bit          m_ce [NL];
   logic [63:0] m_mem [NL][D];
   bit          m_vld [NL][D];
   logic [63:0] m_rd [NL];
   bit          m_rdv [NL];

   function automatic int m_used(int l);
      return (m_w[l] - m_r[l] + D) % D;
   endfunction

   function automatic int g_wptr(int l);  return int'(bus1.ticket_wptr_flat[l*AW +: AW]); endfunction
   function automatic int g_used(int l);  return int'(bus1.used_flat[l*UW +: UW]);        endfunction
   function automatic int g_ovf(int l);   return int'(bus1.ovf_cnt_flat[l*CW +: CW]);     endfunction
   function automatic logic [63:0] g_rd(int l); return bus1.ticket_rd_data_flat[l*TW +: TW]; endfunction

   task automatic clr_stim();
      for (int l = 0; l < NL; l++) begin
         s_wv[l] = 0; s_fl[l] = 0; s_cv[l] = 0; s_wd[l] = '0; s_cr[l] = 0; s_ra[l] = 0;
      end
      bus0.wr_valid = '0; bus0.wr_data_flat = '0; bus0.flush = '0;
      bus0.ticket_rd_addr_flat = '0; bus0.ticket_credit_update_valid = '0;
      bus0.ticket_credit_update_flat = '0;
   endtask

   task automatic tick();
      for (int l = 0; l < NL; l++) begin
         bus1.wr_valid[l]                              = s_wv[l];
         bus1.wr_data_flat[l*TW +: TW]                 = s_wd[l];
         bus1.flush[l]                                 = s_fl[l];
         bus1.ticket_credit_update_valid[l]            = s_cv[l];
         bus1.ticket_credit_update_flat[l*AW +: AW]    = AW'(s_cr[l]);
         bus1.ticket_rd_addr_flat[l*AW +: AW]          = AW'(s_ra[l]);
      end
      for (int l = 0; l < NL; l++) begin
         automatic int used = m_used(l);
         automatic int nr   = m_r[l];
         m_rd[l]  = m_mem[l][s_ra[l]];
         m_rdv[l] = m_vld[l][s_ra[l]];
         if (s_cv[l]) begin
            if ((s_cr[l] - m_r[l] + D) % D <= used) nr = s_cr[l];
            else m_ce[l] = 1;
         end
         if (s_fl[l]) begin
            m_w[l] = nr;
         end else if (s_wv[l] && used < D - 1) begin
            m_mem[l][m_w[l]] = s_wd[l];
            m_vld[l][m_w[l]] = 1;
            m_w[l] = (m_w[l] + 1) % D;
         end else if (s_wv[l]) begin
            if (m_ovf[l] < 65535) m_ovf[l]++;
            m_st[l] = 1;
         end
         m_r[l] = nr;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clr_stim();
      for (int l = 0; l < NL; l++) begin
         m_w[l] = 0; m_r[l] = 0; m_ovf[l] = 0; m_st[l] = 0; m_ce[l] = 0; m_rdv[l] = 0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic write_n(int l, int n);
      for (int i = 0; i < n; i++) begin
         s_wv[l] = 1;
         s_wd[l] = {$urandom, $urandom};
         tick();
      end
      s_wv[l] = 0;
   endtask

   task automatic credit(int l, int c);
      s_cv[l] = 1;
      s_cr[l] = c;
      tick();
      s_cv[l] = 0;
   endtask

   task automatic test_reset();
      clr_stim();
      #1 rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus1.ticket_wptr_flat !== '0 || bus1.used_flat !== '0 || bus1.afull !== '0 ||
          bus1.ticket_rd_data_flat !== '0 || bus1.ovf_cnt_flat !== '0 ||
          bus1.ovf_sticky !== '0 || bus1.credit_err !== '0) begin
         n_fail++;
         $display("FAIL reset_drop wptr=%0h used=%0h afull=%0b ovf=%0h sticky=%0b cerr=%0b exp all 0",
                  bus1.ticket_wptr_flat, bus1.used_flat, bus1.afull, bus1.ovf_cnt_flat,
                  bus1.ovf_sticky, bus1.credit_err);
      end
      n_checks++;
      if (bus1.wr_ready !== 4'hF || bus0.wr_ready !== 4'hF) begin
         n_fail++;
         $display("FAIL reset_ready got drop=%0h bp=%0h exp F/F", bus1.wr_ready, bus0.wr_ready);
      end
      n_checks++;
      if (bus0.used_flat !== '0 || bus0.ticket_wptr_flat !== '0 || bus0.ovf_cnt_flat !== '0) begin
         n_fail++;
         $display("FAIL reset_bp used=%0h wptr=%0h ovf=%0h exp 0",
                  bus0.used_flat, bus0.ticket_wptr_flat, bus0.ovf_cnt_flat);
      end
      do_reset();
   endtask

   task automatic test_basic();
      logic [63:0] tk [5];
      do_reset();
      for (int i = 0; i < 5; i++) begin
         tk[i] = {$urandom, $urandom};
         s_wv[2] = 1; s_wd[2] = tk[i];
         tick();
      end
      s_wv[2] = 0;
      n_checks++;
      if (g_wptr(2) !== 5 || g_used(2) !== 5) begin
         n_fail++;
         $display("FAIL basic_lane2 got wptr=%0d used=%0d exp 5/5", g_wptr(2), g_used(2));
      end
      n_checks++;
      if (g_wptr(0) !== 0 || g_wptr(1) !== 0 || g_wptr(3) !== 0) begin
         n_fail++;
         $display("FAIL basic_other_lanes got wptr=%0h exp 0 outside lane2", bus1.ticket_wptr_flat);
      end
      s_ra[2] = 3;
      tick();
      n_checks++;
      if (g_rd(2) !== tk[3]) begin
         n_fail++;
         $display("FAIL basic_read got=%0h exp=%0h", g_rd(2), tk[3]);
      end
   endtask

   task automatic test_fill();
      int acc0 = 0;
      do_reset();
      for (int n = 1; n <= 1030; n++) begin
         automatic logic [63:0] d = {$urandom, $urandom};
         automatic bit exp_rdy = (acc0 < D - 1);
         n_checks++;
         if (bus0.wr_ready[0] !== exp_rdy) begin
            n_fail++;
            $display("FAIL fill_bp_ready n=%0d got=%0b exp=%0b", n, bus0.wr_ready[0], exp_rdy);
         end
         s_wv[0] = 1; s_wd[0] = d;
         bus0.wr_valid[0] = 1'b1; bus0.wr_data_flat[63:0] = d;
         tick();
         if (exp_rdy) acc0++;
         if (n == 767 || n == 768) begin
            n_checks++;
            if (bus1.afull[0] !== (n == 768)) begin
               n_fail++;
               $display("FAIL fill_afull n=%0d got=%0b exp=%0b", n, bus1.afull[0], n == 768);
            end
         end
      end
      s_wv[0] = 0; bus0.wr_valid = '0;
      tick();
      n_checks++;
      if (g_used(0) !== 1023 || g_ovf(0) !== 7 || bus1.ovf_sticky[0] !== 1'b1 ||
          bus1.afull[0] !== 1'b1 || bus1.wr_ready[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL fill_drop got used=%0d ovf=%0d sticky=%0b afull=%0b rdy=%0b exp 1023/7/1/1/1",
                  g_used(0), g_ovf(0), bus1.ovf_sticky[0], bus1.afull[0], bus1.wr_ready[0]);
      end
      n_checks++;
      if (bus0.used_flat[10:0] !== 11'd1023 || bus0.ovf_cnt_flat[15:0] !== 16'd0 ||
          bus0.ovf_sticky[0] !== 1'b0 || bus0.wr_ready[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL fill_bp got used=%0d ovf=%0d sticky=%0b rdy=%0b exp 1023/0/0/0",
                  bus0.used_flat[10:0], bus0.ovf_cnt_flat[15:0], bus0.ovf_sticky[0],
                  bus0.wr_ready[0]);
      end
      s_fl[0] = 1;
      tick();
      s_fl[0] = 0;
      n_checks++;
      if (g_used(0) !== 0 || g_wptr(0) !== 0 || g_ovf(0) !== 7 || bus1.ovf_sticky[0] !== 1'b1 ||
          bus1.afull[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL fill_flush got used=%0d wptr=%0d ovf=%0d sticky=%0b afull=%0b exp 0/0/7/1/0",
                  g_used(0), g_wptr(0), g_ovf(0), bus1.ovf_sticky[0], bus1.afull[0]);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      write_n(1, 1020);
      credit(1, 1020);
      n_checks++;
      if (g_used(1) !== 0 || g_wptr(1) !== 1020) begin
         n_fail++;
         $display("FAIL wrap_setup got used=%0d wptr=%0d exp 0/1020", g_used(1), g_wptr(1));
      end
      write_n(1, 8);
      n_checks++;
      if (g_wptr(1) !== 4 || g_used(1) !== 8) begin
         n_fail++;
         $display("FAIL wrap_write got wptr=%0d used=%0d exp 4/8", g_wptr(1), g_used(1));
      end
      credit(1, 1022);
      n_checks++;
      if (g_used(1) !== 6) begin
         n_fail++;
         $display("FAIL wrap_credit2 got used=%0d exp 6", g_used(1));
      end
      credit(1, 2);
      n_checks++;
      if (g_used(1) !== 2 || g_wptr(1) !== 4 || bus1.credit_err[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL wrap_credit_to2 got used=%0d wptr=%0d cerr=%0b exp 2/4/0",
                  g_used(1), g_wptr(1), bus1.credit_err[1]);
      end
      s_ra[1] = 1023;
      tick();
      n_checks++;
      if (m_rdv[1] !== 1'b1 || g_rd(1) !== m_rd[1]) begin
         n_fail++;
         $display("FAIL wrap_read got=%0h exp=%0h", g_rd(1), m_rd[1]);
      end
   endtask

   task automatic test_credit_err();
      do_reset();
      write_n(3, 10);
      credit(3, 10);
      write_n(3, 3);
      credit(3, 20);
      n_checks++;
      if (bus1.credit_err[3] !== 1'b1 || g_used(3) !== 3 || g_wptr(3) !== 13) begin
         n_fail++;
         $display("FAIL credit_illegal got cerr=%0b used=%0d wptr=%0d exp 1/3/13",
                  bus1.credit_err[3], g_used(3), g_wptr(3));
      end
      s_wv[3] = 1; s_wd[3] = {$urandom, $urandom};
      credit(3, 13);
      s_wv[3] = 0;
      n_checks++;
      if (g_used(3) !== 1 || g_wptr(3) !== 14 || bus1.credit_err[3] !== 1'b1 ||
          bus1.credit_err[2:0] !== 3'b000) begin
         n_fail++;
         $display("FAIL credit_with_write got used=%0d wptr=%0d cerr=%0h exp 1/14/8",
                  g_used(3), g_wptr(3), bus1.credit_err);
      end
   endtask

   task automatic test_flush();
      do_reset();
      write_n(2, 10);
      s_wv[2] = 1; s_wd[2] = {$urandom, $urandom}; s_fl[2] = 1;
      credit(2, 4);
      s_wv[2] = 0; s_fl[2] = 0;
      n_checks++;
      if (g_wptr(2) !== 4 || g_used(2) !== 0 || g_ovf(2) !== 0 || bus1.ovf_sticky[2] !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_combo got wptr=%0d used=%0d ovf=%0d sticky=%0b exp 4/0/0/0",
                  g_wptr(2), g_used(2), g_ovf(2), bus1.ovf_sticky[2]);
      end
      write_n(2, 1);
      n_checks++;
      if (g_wptr(2) !== 5 || g_used(2) !== 1) begin
         n_fail++;
         $display("FAIL flush_after_write got wptr=%0d used=%0d exp 5/1", g_wptr(2), g_used(2));
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int cyc = 0; cyc < 4000; cyc++) begin
         for (int l = 0; l < NL; l++) begin
            s_wv[l] = ($urandom_range(0, 3) != 0);
            s_wd[l] = {$urandom, $urandom};
            s_fl[l] = ($urandom_range(0, 299) == 0);
            s_cv[l] = (cyc < 1500) ? ($urandom_range(0, 49) == 0) : ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) s_cr[l] = $urandom_range(0, D - 1);
            else s_cr[l] = (m_r[l] + $urandom_range(0, m_used(l))) % D;
            s_ra[l] = $urandom_range(0, 1) ? (m_w[l] + D - 1) % D : $urandom_range(0, D - 1);
         end
         tick();
         for (int l = 0; l < NL; l++) begin
            n_checks++;
            if (g_wptr(l) !== m_w[l] || g_used(l) !== m_used(l)) begin
               n_fail++;
               $display("FAIL rand_ptr cyc=%0d lane=%0d got wptr=%0d used=%0d exp %0d/%0d",
                        cyc, l, g_wptr(l), g_used(l), m_w[l], m_used(l));
            end
            n_checks++;
            if (bus1.afull[l] !== (m_used(l) >= 768) || bus1.wr_ready[l] !== 1'b1) begin
               n_fail++;
               $display("FAIL rand_flags cyc=%0d lane=%0d got afull=%0b rdy=%0b exp %0b/1",
                        cyc, l, bus1.afull[l], bus1.wr_ready[l], m_used(l) >= 768);
            end
            n_checks++;
            if (g_ovf(l) !== m_ovf[l] || bus1.ovf_sticky[l] !== m_st[l] ||
                bus1.credit_err[l] !== m_ce[l]) begin
               n_fail++;
               $display("FAIL rand_acct cyc=%0d lane=%0d got ovf=%0d st=%0b ce=%0b exp %0d/%0b/%0b",
                        cyc, l, g_ovf(l), bus1.ovf_sticky[l], bus1.credit_err[l],
                        m_ovf[l], m_st[l], m_ce[l]);
            end
            if (m_rdv[l]) begin
               n_checks++;
               if (g_rd(l) !== m_rd[l]) begin
                  n_fail++;
                  $display("FAIL rand_read cyc=%0d lane=%0d got=%0h exp=%0h",
                           cyc, l, g_rd(l), m_rd[l]);
               end
            end
         end
      end
      clr_stim();
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         for (int l = 0; l < 3; l++) begin
            s_wv[l] = 1; s_wd[l] = {$urandom, $urandom}; s_ra[l] = 0;
         end
         tick();
      end
      s_cv[1] = 1; s_cr[1] = 40;
      tick();
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus1.ticket_wptr_flat !== '0 || bus1.used_flat !== '0 || bus1.afull !== '0 ||
          bus1.ticket_rd_data_flat !== '0 || bus1.ovf_cnt_flat !== '0 ||
          bus1.ovf_sticky !== '0 || bus1.credit_err !== '0) begin
         n_fail++;
         $display("FAIL async_reset wptr=%0h used=%0h cerr=%0b rd=%0h exp all 0",
                  bus1.ticket_wptr_flat, bus1.used_flat, bus1.credit_err,
                  bus1.ticket_rd_data_flat);
      end
      do_reset();
      n_checks++;
      if (g_used(0) !== 0 || g_used(1) !== 0 || g_used(2) !== 0 || bus1.credit_err !== '0) begin
         n_fail++;
         $display("FAIL async_reset_release used=%0h cerr=%0b exp 0", bus1.used_flat,
                  bus1.credit_err);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_fill();
      test_wrap();
      test_credit_err();
      test_flush();
      test_random();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
